tsv_frame_rx: RTL and testbench
===============================

// Module: tsv_frame_rx
// PURPOSE
//  Lower-tier receiving end of a narrow serialized TSV link from the upper-tier die.
//  The upper tier sends WORD_W-bit words as BEATS = WORD_W/LANES beats over LANES TSV data lanes.
//  This block reassembles each frame and buffers words in a DEPTH-entry FIFO.
//  It presents words on a valid/ready interface and returns flow-control credits back up the TSV stack.
// PARAMETERS
//  LANES   4   TSV data lanes per beat; WORD_W % LANES == 0
//  WORD_W  32  reassembled word width; BEATS = WORD_W/LANES >= 2
//  DEPTH   4   FIFO entries, equal to the transmitter's initial credit count; power of 2
// PORTS
//  clk1      in   1        single clock for all logic
//  rst_n     in   1        asynchronous, active-low reset
//  tsv_vld   in   1        beat valid from TSV
//  tsv_sof   in   1        start of frame; qualified by tsv_vld
//  tsv_dat   in   LANES    beat payload
//  tsv_par   in   1        even parity over tsv_dat
//  tsv_crd   out  1        credit return, one-cycle pulse per credit
//  rx_data   out  WORD_W   FIFO head word
//  rx_valid  out  1        FIFO non-empty
//  rx_ready  in   1        consumer accept; pop = rx_valid & rx_ready
//  par_err   out  1        sticky parity error
//  frm_err   out  1        sticky framing/overflow error
//  err_clr   in   1        clears par_err and frm_err
// BEHAVIOUR
//  - Reset: tsv_crd, rx_valid, rx_data, par_err, frm_err = 0; FIFO empty; FSM IDLE; partial frame and pending credits discarded. Takes effect immediately, mid-frame included.
//  - Beat order: LSB first; beat k fills word bits [k*LANES +: LANES].
//  - FSM IDLE:
//    - tsv_vld & tsv_sof: capture beat 0, beat count = 1, go to RECV.
//    - tsv_vld & !tsv_sof: set frm_err; drop the beat.
//  - FSM RECV:
//    - tsv_vld & !tsv_sof: capture the next beat. Idle gaps (tsv_vld = 0) are allowed between beats.
//    - tsv_vld & tsv_sof: set frm_err; discard the partial frame; capture this beat as beat 0 and stay in RECV. No credit is returned for the aborted frame.
//    - Last beat (count == BEATS-1): the word completes in this cycle; FSM goes to IDLE. A sof beat in the very next cycle is accepted.
//  - Push: a completed word is written into the FIFO in the completion cycle.
//    - Latency: last beat at cycle N gives rx_valid = 1 at N+1 when the FIFO was empty.
//    - If the FIFO is full and no pop occurs that cycle (credit violation): set frm_err; drop the word; return no credit.
//    - Full FIFO with a simultaneous pop: the push is accepted.
//  - FIFO output: in-order delivery. rx_data holds stable while rx_valid & !rx_ready.
//  - Credits:
//    - Each pop adds one pending credit.
//    - A pending-credit counter (0..DEPTH) drives tsv_crd: one pulse per cycle while the counter is non-zero.
//    - The first pulse appears in the cycle after the event.
//    - Two credit events in the same cycle produce pulses on two consecutive cycles.
//  - Errors: par_err and frm_err are sticky until err_clr. If err_clr and a new error event occur in the same cycle, set wins.
// CONFIGURATION
//  TSV_RX_PARITY_EN defined:
//   - Every valid beat is checked: ^{tsv_dat,tsv_par} must be 0.
//   - On mismatch: set par_err and mark the frame bad.
//   - A bad frame is dropped at completion (no push) and adds one pending credit.
//  TSV_RX_PARITY_EN undefined:
//   - tsv_par is ignored; par_err is tied to 0; no frame is ever dropped for parity.
// TESTING  (LANES=4, WORD_W=32, DEPTH=4)
//  1. Frame beats 1,2,...,8 with sof on beat 1, rx_ready=1 -> rx_data=32'h87654321 and rx_valid high for exactly 1 cycle, at N+1; tsv_crd pulse at N+2.
//  2. rx_ready=0, four frames -> rx_valid held and rx_data stable; 5th frame -> frm_err=1, word dropped; drain -> 4 words in order, 4 tsv_crd pulses.
//  3. sof after 3 beats of a frame -> frm_err=1; the frame restarted by that sof beat is delivered intact; err_clr -> frm_err=0.
//  4. TSV_RX_PARITY_EN: beat 5 parity flipped -> par_err=1, no rx_valid, one tsv_crd pulse. Without the macro -> word delivered, par_err=0.
//  5. rst_n low after beat 4 -> all outputs 0 immediately; after release, a full frame 0xA5A5A5A5 is received correctly.
//  6. Pop and parity drop in the same cycle -> tsv_crd pulses on two consecutive cycles; no pulse is lost.

Source files
------------

// File: rtl/tsv_frame_rx.sv
// Lower-tier TSV frame receiver: beat reassembly, word FIFO, credit return to the upper tier.
// Build macro TSV_RX_PARITY_EN enables per-beat even-parity checking and bad-frame drop.
module tsv_frame_rx #(
    parameter int LANES  = 4,
    parameter int WORD_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic              clk1,
    input  logic              rst_n,
    input  logic              tsv_vld,
    input  logic              tsv_sof,
    input  logic [LANES-1:0]  tsv_dat,
    input  logic              tsv_par,
    output logic              tsv_crd,
    output logic [WORD_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              par_err,
    output logic              frm_err,
    input  logic              err_clr
);
    localparam int BEATS = WORD_W / LANES;
    localparam int CNT_W = $clog2(BEATS);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BEATS - 1);

    typedef enum logic {
        S_IDLE,
        S_RECV
    } state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt, beat_idx;
    logic               cap_beat, restart, word_done, seq_err;
    logic [WORD_W-1:0]  word_buf, asm_word;
    logic               frm_bad, beat_bad, done_bad;
    logic               push_req, push, pop, full, ovf, bad_drop;
    logic [WORD_W-1:0]  mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [OCC_W-1:0]   occ, crd_cnt;

    // ---------------- frame reassembly FSM ----------------
    // NOTE: state and counters use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // NOTE: every output of this block is defaulted first so no latch can be inferred.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        beat_idx  = cnt;
        cap_beat  = 1'b0;
        restart   = 1'b0;
        word_done = 1'b0;
        seq_err   = 1'b0;
        case (state)
            S_IDLE: begin
                if (tsv_vld) begin
                    if (tsv_sof) begin
                        cap_beat  = 1'b1;
                        restart   = 1'b1;
                        beat_idx  = '0;
                        cnt_nxt   = CNT_W'(1);
                        state_nxt = S_RECV;
                    end else begin
                        seq_err = 1'b1;
                    end
                end
            end
            S_RECV: begin
                if (tsv_vld) begin
                    if (tsv_sof) begin
                        // Abort: the sof beat becomes beat 0 of a fresh frame.
                        seq_err  = 1'b1;
                        cap_beat = 1'b1;
                        restart  = 1'b1;
                        beat_idx = '0;
                        cnt_nxt  = CNT_W'(1);
                    end else if (cnt == LAST) begin
                        word_done = 1'b1;
                        cnt_nxt   = '0;
                        state_nxt = S_IDLE;
                    end else begin
                        cap_beat = 1'b1;
                        cnt_nxt  = cnt + CNT_W'(1);
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Payload holding register is pure datapath; validity is tracked by the FSM.
    always_ff @(posedge clk1) begin
        if (cap_beat)
            word_buf[int'(beat_idx)*LANES +: LANES] <= tsv_dat;
    end

    // The last beat bypasses word_buf so the word is pushed in its completion cycle.
    assign asm_word = {tsv_dat, word_buf[WORD_W-LANES-1:0]};

    // ---------------- parity ----------------
`ifdef TSV_RX_PARITY_EN
    assign beat_bad = tsv_vld & (^{tsv_dat, tsv_par});
`else
    logic par_unused;
    assign par_unused = tsv_par;
    assign beat_bad   = 1'b0;
`endif

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n)
            frm_bad <= 1'b0;
        else if (restart)
            frm_bad <= beat_bad;
        else if (cap_beat)
            frm_bad <= frm_bad | beat_bad;
        else if (word_done)
            frm_bad <= 1'b0;
    end

    assign done_bad = frm_bad | beat_bad;
    assign push_req = word_done & ~done_bad;
    assign bad_drop = word_done & done_bad;

    // ---------------- word FIFO ----------------
    assign rx_valid = (occ != '0);
    assign full     = (occ == OCC_W'(DEPTH));
    assign pop      = rx_valid & rx_ready;
    assign push     = push_req & (~full | pop);
    assign ovf      = push_req & full & ~pop;
    assign rx_data  = rx_valid ? mem[rd_ptr] : '0;

    // NOTE: storage is not reset; occupancy gates rx_data, so stale contents are never visible.
    always_ff @(posedge clk1) begin
        if (push)
            mem[wr_ptr] <= asm_word;
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            occ <= occ + OCC_W'(push) - OCC_W'(pop);
        end
    end

    // ---------------- credit return ----------------
    // A pop and a bad-frame drop can land together; the counter spreads them over two cycles.
    assign tsv_crd = (crd_cnt != '0);

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n)
            crd_cnt <= '0;
        else
            crd_cnt <= crd_cnt + OCC_W'(pop) + OCC_W'(bad_drop) - OCC_W'(tsv_crd);
    end

    // ---------------- sticky errors (set wins over clear) ----------------
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n)
            frm_err <= 1'b0;
        else
            frm_err <= (frm_err & ~err_clr) | seq_err | ovf;
    end

`ifdef TSV_RX_PARITY_EN
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n)
            par_err <= 1'b0;
        else
            par_err <= (par_err & ~err_clr) | beat_bad;
    end
`else
    assign par_err = 1'b0;
`endif

endmodule

// File: tb/tb_tsv_frame_rx.sv
// Directed bench for tsv_frame_rx (LANES=4, WORD_W=32, DEPTH=4): vector table plus corner sequences.
module tb_tsv_frame_rx;
    logic        clk1 = 1'b0;
    logic        rst_n;
    logic        tsv_vld, tsv_sof, tsv_par, rx_ready, err_clr;
    logic [3:0]  tsv_dat;
    logic        tsv_crd, rx_valid, par_err, frm_err;
    logic [31:0] rx_data;

    int total = 0;
    int bad   = 0;
    int crd_seen = 0;

    typedef struct {
        logic        vld;
        logic        sof;
        logic [3:0]  dat;
        logic        rdy;
        logic        e_valid;
        logic [31:0] e_data;
        logic        e_crd;
        logic        e_frm;
    } vec_t;

    vec_t vecs[10];

    tsv_frame_rx #(.LANES(4), .WORD_W(32), .DEPTH(4)) dut (
        .clk1     (clk1),
        .rst_n    (rst_n),
        .tsv_vld  (tsv_vld),
        .tsv_sof  (tsv_sof),
        .tsv_dat  (tsv_dat),
        .tsv_par  (tsv_par),
        .tsv_crd  (tsv_crd),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .par_err  (par_err),
        .frm_err  (frm_err),
        .err_clr  (err_clr)
    );

    always #5 clk1 = ~clk1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs (called at a negedge), clock it, return at the next negedge.
    task automatic step(input logic vld, input logic sof, input logic [3:0] dat, input logic flip);
        tsv_vld = vld;
        tsv_sof = sof;
        tsv_dat = dat;
        tsv_par = (^dat) ^ flip;
        @(posedge clk1);
        @(negedge clk1);
        if (tsv_crd) crd_seen++;
        tsv_vld = 1'b0;
        tsv_sof = 1'b0;
    endtask

    task automatic send_frame(input logic [31:0] word, input int flip_beat);
        for (int k = 0; k < 8; k++)
            step(1'b1, k == 0, word[k*4 +: 4], k == flip_beat);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++)
            step(1'b0, 1'b0, 4'h0, 1'b0);
    endtask

    logic [31:0] w [5];

    initial begin
        rst_n = 1'b0; tsv_vld = 1'b0; tsv_sof = 1'b0; tsv_dat = '0; tsv_par = 1'b0;
        rx_ready = 1'b0; err_clr = 1'b0;
        repeat (2) @(negedge clk1);
        check("reset rx_valid", rx_valid, 0);
        check("reset rx_data", rx_data, 0);
        check("reset tsv_crd", tsv_crd, 0);
        check("reset frm_err", frm_err, 0);
        check("reset par_err", par_err, 0);
        rst_n = 1'b1;
        idle(1);

        // Test 1: vector table, beats 1..8 -> 32'h87654321, rx_valid at N+1, credit at N+2.
        for (int k = 0; k < 8; k++)
            vecs[k] = '{1'b1, k == 0, 4'(k + 1), 1'b1, k == 7, 32'h8765_4321, 1'b0, 1'b0};
        vecs[8] = '{1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0};
        vecs[9] = '{1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx_ready = vecs[i].rdy;
            step(vecs[i].vld, vecs[i].sof, vecs[i].dat, 1'b0);
            check($sformatf("t1[%0d] rx_valid", i), rx_valid, vecs[i].e_valid);
            check($sformatf("t1[%0d] tsv_crd", i), tsv_crd, vecs[i].e_crd);
            check($sformatf("t1[%0d] frm_err", i), frm_err, vecs[i].e_frm);
            if (vecs[i].e_valid)
                check($sformatf("t1[%0d] rx_data", i), rx_data, vecs[i].e_data);
        end

        // Test 2: fill FIFO with rx_ready=0, overflow, then drain in order.
        w[0] = 32'h0123_4567; w[1] = 32'h89AB_CDEF; w[2] = 32'h1357_9BDF;
        w[3] = 32'h2468_ACE0; w[4] = 32'hFFFF_0000;
        rx_ready = 1'b0;
        crd_seen = 0;
        for (int i = 0; i < 4; i++) begin
            send_frame(w[i], -1);
            check($sformatf("t2 fill%0d rx_valid", i), rx_valid, 1);
            check($sformatf("t2 fill%0d rx_data", i), rx_data, w[0]);
        end
        check("t2 no frm_err before overflow", frm_err, 0);
        send_frame(w[4], -1);
        check("t2 overflow frm_err", frm_err, 1);
        check("t2 overflow head", rx_data, w[0]);
        check("t2 no credit while full", crd_seen, 0);
        rx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t2 drain%0d rx_valid", i), rx_valid, 1);
            check($sformatf("t2 drain%0d rx_data", i), rx_data, w[i]);
            idle(1);
        end
        check("t2 empty after drain", rx_valid, 0);
        idle(2);
        check("t2 credit pulses", crd_seen, 4);
        check("t2 tsv_crd idle", tsv_crd, 0);
        err_clr = 1'b1; idle(1); err_clr = 1'b0;
        check("t2 err_clr frm_err", frm_err, 0);

        // Test 3: sof after 3 beats restarts the frame; idle gap mid-frame; set wins over clear.
        rx_ready = 1'b1;
        crd_seen = 0;
        for (int k = 0; k < 3; k++)
            step(1'b1, k == 0, 4'hA, 1'b0);
        check("t3 partial no frm_err", frm_err, 0);
        w[0] = 32'h3C5A_96E1;
        step(1'b1, 1'b1, w[0][3:0], 1'b0);
        check("t3 sof abort frm_err", frm_err, 1);
        for (int k = 1; k < 8; k++) begin
            step(1'b1, 1'b0, w[0][k*4 +: 4], 1'b0);
            if (k == 3) idle(1);
        end
        check("t3 restarted rx_valid", rx_valid, 1);
        check("t3 restarted rx_data", rx_data, w[0]);
        idle(3);
        check("t3 one credit", crd_seen, 1);
        err_clr = 1'b1; idle(1);
        check("t3 err_clr frm_err", frm_err, 0);
        step(1'b1, 1'b0, 4'h5, 1'b0);
        check("t3 set wins over clear", frm_err, 1);
        idle(1); err_clr = 1'b0;
        check("t3 cleared again", frm_err, 0);

        // Test 4: parity flipped on beat 5.
        crd_seen = 0;
        w[0] = 32'h7654_3210;
        send_frame(w[0], 4);
`ifdef TSV_RX_PARITY_EN
        check("t4 bad frame dropped", rx_valid, 0);
        check("t4 par_err", par_err, 1);
`else
        check("t4 word delivered", rx_valid, 1);
        check("t4 word data", rx_data, w[0]);
        check("t4 par_err tied low", par_err, 0);
`endif
        idle(3);
        check("t4 one credit", crd_seen, 1);
        err_clr = 1'b1; idle(1); err_clr = 1'b0;
        check("t4 par_err cleared", par_err, 0);
        check("t4 frm_err clean", frm_err, 0);

        // Test 5: asynchronous reset mid-frame with state pending everywhere.
        rx_ready = 1'b0;
        step(1'b1, 1'b0, 4'h3, 1'b0);
        send_frame(32'h0F1E_2D3C, -1);
        send_frame(32'h4B5A_6978, -1);
        for (int k = 0; k < 4; k++) begin
            rx_ready = (k == 3);
            step(1'b1, k == 0, 4'h6, 1'b0);
        end
        rx_ready = 1'b0;
        check("t5 pre-reset tsv_crd", tsv_crd, 1);
        check("t5 pre-reset rx_valid", rx_valid, 1);
        check("t5 pre-reset frm_err", frm_err, 1);
        rst_n = 1'b0;
        #1;
        check("t5 reset rx_valid", rx_valid, 0);
        check("t5 reset rx_data", rx_data, 0);
        check("t5 reset tsv_crd", tsv_crd, 0);
        check("t5 reset frm_err", frm_err, 0);
        check("t5 reset par_err", par_err, 0);
        @(negedge clk1);
        idle(1);
        rst_n = 1'b1;
        rx_ready = 1'b1;
        crd_seen = 0;
        send_frame(32'hA5A5_A5A5, -1);
        check("t5 post-reset rx_valid", rx_valid, 1);
        check("t5 post-reset rx_data", rx_data, 32'hA5A5_A5A5);
        check("t5 post-reset frm_err", frm_err, 0);
        idle(3);
        check("t5 post-reset credit", crd_seen, 1);

        // Test 6: pop and completion of a parity-flipped frame in the same cycle.
        rx_ready = 1'b0;
        w[0] = 32'h1122_3344; w[1] = 32'h5566_7788;
        send_frame(w[0], -1);
        for (int k = 0; k < 7; k++)
            step(1'b1, k == 0, w[1][k*4 +: 4], k == 2);
        check("t6 no credit yet", tsv_crd, 0);
        rx_ready = 1'b1;
        step(1'b1, 1'b0, w[1][31:28], 1'b0);
        check("t6 first pulse", tsv_crd, 1);
`ifdef TSV_RX_PARITY_EN
        check("t6 dropped frame not visible", rx_valid, 0);
`else
        check("t6 second word visible", rx_valid, 1);
        check("t6 second word data", rx_data, w[1]);
`endif
        idle(1);
        check("t6 second pulse", tsv_crd, 1);
        idle(1);
        check("t6 pulses end", tsv_crd, 0);
        check("t6 fifo empty", rx_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
